cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step/breakpoint controller directly upstream of the 5-stage LA32 pipeline CPU top.
- Turns board buttons into a one-cycle CPU clock-enable (cpu_en), which gates every pipeline register and the PC update.
- Watches the fetch PC for a breakpoint and counts enabled cycles for the debug display.

Parameters:
- SYNC_STAGES, 2: flops in each button synchronizer (≥2).
- STEP_CYCLES, 1: enabled cycles issued per step press (1..255).
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- run_btn  in  1  asynchronous button: start/resume free run
- step_btn  in  1  asynchronous button: issue STEP_CYCLES enabled cycles
- stop_btn  in  1  asynchronous button: halt
- cnt_clr  in  1  synchronous clear of cycle_cnt
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- pc  in  32  current fetch PC from the CPU
- cpu_en  out  1  pipeline clock-enable
- state  out  2  0=HALT, 1=RUN, 2=STEP, 3=BREAK
- bp_hit  out  1  high while state==BREAK
- cycle_cnt  out  CNT_W  enabled-cycle count

Behaviour:
- Reset (async, rstn=0): state=HALT, cpu_en=0, bp_hit=0, cycle_cnt=0, step counter=0, skip flag=0, all synchronizer and edge flops=0. Reset mid-RUN or mid-STEP stops the CPU in the same instant.
- Button path:
  - Each button passes through SYNC_STAGES flops and then a rising-edge detector, giving a one-cycle pulse (run_p, step_p, stop_p).
  - Latency from input rise to pulse is SYNC_STAGES+1 clocks.
  - A held button yields exactly one pulse.
- Pulse priority when simultaneous: stop_p > step_p > run_p. Lower-priority pulses in the same cycle are dropped.
- bp_match = bp_en && (pc == bp_addr) && !skip.
- cpu_en is a combinational decode: 1 when (state==RUN && !bp_match) or state==STEP; otherwise 0. When a breakpoint is hit, the CPU holds with pc == bp_addr and that instruction not yet fetched into IF/ID.
- State transitions (registered):
  - HALT: stop_p → stay. step_p → STEP, step counter = STEP_CYCLES. run_p → RUN, skip = bp_match_raw, where bp_match_raw = bp_en && pc==bp_addr.
  - RUN: stop_p → HALT. bp_match (with no stop_p) → BREAK. step_p and run_p are ignored.
  - STEP: breakpoints are ignored. stop_p → HALT immediately, and cpu_en=0 from the next cycle. Otherwise the counter decrements each cycle; when the counter equals 1 → HALT. Exactly STEP_CYCLES enabled cycles are issued. step_p and run_p are ignored.
  - BREAK: stop_p → HALT. step_p → STEP (counter = STEP_CYCLES). run_p → RUN with skip=1.
- Skip flag: set on entry to RUN from BREAK (or from HALT when already sitting on bp_addr). It is cleared in the first cycle pc != bp_addr, so the same breakpoint is re-armed once the CPU leaves it. It is also cleared on any transition to HALT.
- cycle_cnt:
  - Increments by 1 in every cycle with cpu_en=1 and wraps from 2^CNT_W−1 to 0.
  - cnt_clr=1 forces 0 next cycle and has priority over increment.
- bp_addr and bp_en changes take effect the same cycle (combinational compare).
- Changing bp_addr while in BREAK does not leave BREAK.

Test Plan:
- Reset and idle: assert rstn=0 for 3 clk, release, no buttons → state=0, cpu_en=0, cycle_cnt=0 for 20 cycles.
- Free run then stop: pulse run_btn high for 5 cycles, with bp_en=0 and SYNC_STAGES=2 → cpu_en rises exactly 4 clocks after run_btn rises (3-clock sync/edge latency + 1-clock state register), and stays 1 while held. After 100 enabled cycles, press stop → cpu_en=0 within SYNC_STAGES+2 clocks and cycle_cnt frozen at its final value.
- Breakpoint: bp_en=1, bp_addr=0x1C00_0010, model pc advancing +4 from 0x1C00_0000 when cpu_en=1, then press run:
  - pc reaches 0x1C00_0010 → cpu_en=0 that cycle, state=3, bp_hit=1, pc stays 0x1C00_0010.
  - Press run again → pc moves to 0x1C00_0014 without re-breaking.
  - The next pass through 0x1C00_0010 breaks again.
- Step with STEP_CYCLES=3, from HALT: press step once → exactly 3 cycles with cpu_en=1, then state=0 and cycle_cnt +3. Holding step for 50 cycles still gives only 3 cycles.
- Simultaneous and priority: run_btn and stop_btn rise in the same cycle → state remains HALT. step and run rise together from BREAK → state=STEP.
- Wrap, clear and async reset: preload via CNT_W=4, run 17 enabled cycles → cycle_cnt=1. Assert cnt_clr during RUN → 0 next cycle. Drop rstn mid-STEP → cpu_en=0 and state=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller that sits in front of the
// 5-stage LA32 pipeline. Board buttons are synchronized and edge-detected,
// then drive a small FSM whose state decodes into the pipeline clock-enable.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   run_btn    async button, start/resume free run
//   step_btn   async button, issue STEP_CYCLES enabled cycles
//   stop_btn   async button, halt
//   cnt_clr    synchronous clear of cycle_cnt
//   bp_en      breakpoint enable
//   bp_addr    breakpoint PC
//   pc         current fetch PC from the CPU
//   cpu_en     pipeline clock-enable (combinational decode of state)
//   state      0=HALT 1=RUN 2=STEP 3=BREAK
//   bp_hit     high while in BREAK
//   cycle_cnt  count of enabled cycles, wraps
module cpu_run_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             stop_btn,
  input  logic             cnt_clr,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  localparam logic [7:0] STEP_LD = 8'(STEP_CYCLES);

  // Button order in the packed vectors: {stop, step, run}
  logic [SYNC_STAGES-1:0][2:0] btn_sync;
  logic [2:0]                  btn_prev;
  logic [2:0]                  btn_pulse;
  logic                        run_p;
  logic                        step_p;
  logic                        stop_p;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] step_cnt_q;
  logic [7:0] step_cnt_d;
  logic       skip_q;
  logic       skip_d;
  logic       bp_match_raw;
  logic       bp_match;

  // Synchronizer chain, then a registered rising-edge pulse; the pulse
  // register makes the input-to-pulse latency SYNC_STAGES+1 clocks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_sync  <= '0;
      btn_prev  <= '0;
      btn_pulse <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], {stop_btn, step_btn, run_btn}};
      btn_prev  <= btn_sync[SYNC_STAGES-1];
      btn_pulse <= btn_sync[SYNC_STAGES-1] & ~btn_prev;
    end
  end

  assign run_p  = btn_pulse[0];
  assign step_p = btn_pulse[1];
  assign stop_p = btn_pulse[2];

  // Breakpoint compare is combinational so bp_addr/bp_en act in the same
  // cycle; skip suppresses a re-hit on the address we are resuming from.
  assign bp_match_raw = bp_en && (pc == bp_addr);
  assign bp_match     = bp_match_raw && !skip_q;

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    skip_d     = skip_q;
    if (pc != bp_addr) skip_d = 1'b0;

    case (state_q)
      S_HALT: begin
        skip_d = 1'b0;
        if (stop_p) begin
          state_d = S_HALT;
        end else if (step_p) begin
          state_d    = S_STEP;
          step_cnt_d = STEP_LD;
        end else if (run_p) begin
          state_d = S_RUN;
          skip_d  = bp_match_raw;
        end
      end
      S_RUN: begin
        if (stop_p) begin
          state_d = S_HALT;
          skip_d  = 1'b0;
        end else if (bp_match) begin
          state_d = S_BREAK;
        end
      end
      S_STEP: begin
        // The <= guards against a zero count ever looping forever.
        if (stop_p || (step_cnt_q <= 8'd1)) begin
          state_d    = S_HALT;
          step_cnt_d = 8'd0;
          skip_d     = 1'b0;
        end else begin
          step_cnt_d = step_cnt_q - 8'd1;
        end
      end
      S_BREAK: begin
        if (stop_p) begin
          state_d = S_HALT;
          skip_d  = 1'b0;
        end else if (step_p) begin
          state_d    = S_STEP;
          step_cnt_d = STEP_LD;
        end else if (run_p) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_HALT;
        skip_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_HALT;
      step_cnt_q <= 8'd0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      skip_q     <= skip_d;
    end
  end

  // Decoded from the state register so an async reset drops it at once;
  // in RUN the enable is withheld in the very cycle pc lands on bp_addr.
  assign cpu_en = ((state_q == S_RUN) && !bp_match) || (state_q == S_STEP);
  assign state  = state_q;
  assign bp_hit = (state_q == S_BREAK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        run_btn;
  logic        step_btn;
  logic        stop_btn;
  logic        cnt_clr;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc = 32'h0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] cycle_cnt;
  logic        cpu_en_w;
  logic [1:0]  state_w;
  logic        bp_hit_w;
  logic [3:0]  cycle_cnt_w;

  logic        pc_ld;
  logic [31:0] pc_ld_val;

  int total = 0;
  int bad   = 0;
  int n;
  int en_n;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.SYNC_STAGES(2), .STEP_CYCLES(3), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .run_btn(run_btn), .step_btn(step_btn),
    .stop_btn(stop_btn), .cnt_clr(cnt_clr), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit),
    .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctrl #(.SYNC_STAGES(2), .STEP_CYCLES(3), .CNT_W(4)) dut_w (
    .clk(clk), .rstn(rstn), .run_btn(run_btn), .step_btn(step_btn),
    .stop_btn(stop_btn), .cnt_clr(cnt_clr), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en_w), .state(state_w), .bp_hit(bp_hit_w),
    .cycle_cnt(cycle_cnt_w)
  );

  // Fetch PC model: advances by 4 on every enabled cycle, or loads a value.
  always @(posedge clk) begin
    if (pc_ld) pc <= pc_ld_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; run_btn = 1'b0; step_btn = 1'b0; stop_btn = 1'b0;
    cnt_clr = 1'b0; bp_en = 1'b0; bp_addr = 32'h1C00_0010;
    pc_ld = 1'b0; pc_ld_val = 32'h0;

    // Reset and idle
    cyc(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_en", 32'(cpu_en), 0);
    chk("rst_hit", 32'(bp_hit), 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_state_w", 32'(state_w), 0);
    chk("rst_en_w", 32'(cpu_en_w), 0);
    chk("rst_hit_w", 32'(bp_hit_w), 0);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle_state", 32'(state), 0);
      chk("idle_en", 32'(cpu_en), 0);
      chk("idle_cnt", cycle_cnt, 0);
    end

    // Free run then stop
    run_btn = 1'b1;
    cyc(3);
    chk("run_lat3", 32'(cpu_en), 0);
    cyc(1);
    chk("run_lat4", 32'(cpu_en), 1);
    chk("run_state", 32'(state), 1);
    chk("run_cnt0", cycle_cnt, 0);
    cyc(1);
    run_btn = 1'b0;
    cyc(99);
    chk("run_cnt100", cycle_cnt, 100);
    chk("run_en_held", 32'(cpu_en), 1);
    stop_btn = 1'b1;
    cyc(3);
    chk("stop_lat3", 32'(cpu_en), 1);
    cyc(1);
    chk("stop_en", 32'(cpu_en), 0);
    chk("stop_state", 32'(state), 0);
    chk("stop_cnt", cycle_cnt, 104);
    chk("stop_cnt_w", 32'(cycle_cnt_w), 8);
    cyc(10);
    chk("stop_frozen", cycle_cnt, 104);
    stop_btn = 1'b0;
    cyc(3);

    // Breakpoint at 0x1C00_0010
    bp_en = 1'b1;
    pc_ld = 1'b1; pc_ld_val = 32'h1C00_0000;
    cyc(1);
    pc_ld = 1'b0;
    run_btn = 1'b1;
    cyc(2);
    run_btn = 1'b0;
    n = 2;
    while (pc != 32'h1C00_0010 && n < 40) begin cyc(1); n++; end
    chk("bp_reach_pc", pc, 32'h1C00_0010);
    chk("bp_lat", 32'(n), 8);
    chk("bp_en_cut", 32'(cpu_en), 0);
    chk("bp_pre_state", 32'(state), 1);
    cyc(1);
    chk("bp_state", 32'(state), 3);
    chk("bp_hit", 32'(bp_hit), 1);
    chk("bp_en_hold", 32'(cpu_en), 0);
    cyc(5);
    chk("bp_pc_hold", pc, 32'h1C00_0010);
    bp_addr = 32'h1C00_0100;
    cyc(2);
    chk("bp_addr_chg_state", 32'(state), 3);
    chk("bp_addr_chg_en", 32'(cpu_en), 0);
    bp_addr = 32'h1C00_0010;
    cyc(1);

    // Resume from the breakpoint without re-breaking
    run_btn = 1'b1;
    cyc(2);
    run_btn = 1'b0;
    cyc(2);
    chk("res_state", 32'(state), 1);
    chk("res_en", 32'(cpu_en), 1);
    cyc(1);
    chk("res_pc", pc, 32'h1C00_0014);
    chk("res_state2", 32'(state), 1);
    cyc(2);
    pc_ld = 1'b1; pc_ld_val = 32'h1C00_0008;
    cyc(1);
    pc_ld = 1'b0;
    chk("loop_state", 32'(state), 1);
    n = 0;
    while (pc != 32'h1C00_0010 && n < 20) begin cyc(1); n++; end
    chk("rebreak_pc", pc, 32'h1C00_0010);
    chk("rebreak_lat", 32'(n), 2);
    cyc(1);
    chk("rebreak_state", 32'(state), 3);

    // Stop out of BREAK, then single step from HALT
    stop_btn = 1'b1;
    cyc(2);
    stop_btn = 1'b0;
    cyc(3);
    chk("brk_stop_state", 32'(state), 0);
    bp_en = 1'b0;
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("clr_halt", cycle_cnt, 0);
    step_btn = 1'b1;
    en_n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i == 1) step_btn = 1'b0;
      if (cpu_en) en_n++;
    end
    chk("step1_en", 32'(en_n), 3);
    chk("step1_state", 32'(state), 0);
    chk("step1_cnt", cycle_cnt, 3);
    step_btn = 1'b1;
    en_n = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (i == 49) step_btn = 1'b0;
      if (cpu_en) en_n++;
    end
    chk("step_hold_en", 32'(en_n), 3);
    chk("step_hold_state", 32'(state), 0);
    chk("step_hold_cnt", cycle_cnt, 6);

    // Simultaneous presses
    run_btn = 1'b1; stop_btn = 1'b1;
    cyc(3);
    run_btn = 1'b0; stop_btn = 1'b0;
    cyc(5);
    chk("prio_rs_state", 32'(state), 0);
    chk("prio_rs_en", 32'(cpu_en), 0);
    chk("prio_rs_cnt", cycle_cnt, 6);
    bp_en = 1'b1;
    pc_ld = 1'b1; pc_ld_val = 32'h1C00_0000;
    cyc(1);
    pc_ld = 1'b0;
    run_btn = 1'b1;
    cyc(2);
    run_btn = 1'b0;
    n = 2;
    while (pc != 32'h1C00_0010 && n < 40) begin cyc(1); n++; end
    chk("prio_bp_pc", pc, 32'h1C00_0010);
    cyc(1);
    chk("prio_bp_state", 32'(state), 3);
    step_btn = 1'b1; run_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0; run_btn = 1'b0;
    cyc(2);
    chk("prio_sr_state", 32'(state), 2);
    chk("prio_sr_en", 32'(cpu_en), 1);
    cyc(4);
    chk("prio_sr_done", 32'(state), 0);

    // Wrap, clear during RUN, async reset mid-STEP
    bp_en = 1'b0;
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("clr_cnt", cycle_cnt, 0);
    chk("clr_cnt_w", 32'(cycle_cnt_w), 0);
    run_btn = 1'b1;
    cyc(4);
    chk("wrap_run_en", 32'(cpu_en), 1);
    cyc(1);
    run_btn = 1'b0;
    cyc(16);
    chk("wrap_w", 32'(cycle_cnt_w), 1);
    chk("wrap_full", cycle_cnt, 17);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("clr_run", cycle_cnt, 0);
    chk("clr_run_en", 32'(cpu_en), 1);
    cyc(1);
    chk("clr_resume", cycle_cnt, 1);
    stop_btn = 1'b1;
    cyc(2);
    stop_btn = 1'b0;
    cyc(3);
    chk("wrap_stop_state", 32'(state), 0);
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    cyc(3);
    chk("mid_step_state", 32'(state), 2);
    #1 rstn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_en", 32'(cpu_en), 0);
    chk("arst_cnt", cycle_cnt, 0);
    cyc(2);
    rstn = 1'b1;
    cyc(3);
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_en", 32'(cpu_en), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
